// File: rtl/spike_writeback.sv
// spike_writeback: packs encoder spike beats into DDR words (one word per time step),
// buffers them in a FWFT FIFO and bursts them to memory. Optional macro: SPIKE_WB_COUNT_EN.
//
// Handshake: i_spike_valid has no back-pressure; wr_burst_req is held from REQ entry until
// the first wr_burst_data_req, and every data_req in REQ/DATA pops the FIFO head if non-empty.
module spike_writeback #(
    parameter int                    TIME_STEPS = 4,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    ADDR_SIZE  = 32,
    parameter int                    LEN_WIDTH  = 10,
    parameter int                    BURST_LEN  = 16,
    parameter int                    FIFO_DEPTH = 64,
    parameter logic [ADDR_SIZE-1:0]  BASE_ADDR  = 32'h0100_0000
) (
    input  logic                     s_clk,
    input  logic                     s_rst,
    input  logic [TIME_STEPS-1:0]    i_spike,
    input  logic                     i_spike_valid,
    input  logic                     i_enc_done,
    output logic [DATA_WIDTH-1:0]    wr_burst_data,
    output logic [ADDR_SIZE-1:0]     wr_burst_addr,
    output logic [LEN_WIDTH-1:0]     wr_burst_len,
    output logic                     wr_burst_req,
    input  logic                     wr_burst_data_req,
    input  logic                     wr_burst_finish,
    output logic                     o_wb_done,
    output logic                     o_overflow,
    output logic [1:0]               o_dbg_state
`ifdef SPIKE_WB_COUNT_EN
    ,
    output logic [TIME_STEPS*16-1:0] o_spike_cnt
`endif
);

    localparam int CNT_W   = $clog2(DATA_WIDTH);
    localparam int SH_W    = CNT_W + 1;
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int FIFO_CW = FIFO_AW + 1;
    localparam int SEQ_W   = (TIME_STEPS > 1) ? $clog2(TIME_STEPS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2,
        ST_ADV  = 2'd3
    } state_t;

    // ---------------- packing and push sequencer ----------------
    logic [DATA_WIDTH-1:0] shreg_q [TIME_STEPS];
    logic [DATA_WIDTH-1:0] shreg_d [TIME_STEPS];
    logic [DATA_WIDTH-1:0] hold_q  [TIME_STEPS];
    logic [DATA_WIDTH-1:0] hold_d  [TIME_STEPS];
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                  seq_busy_q, seq_busy_d;
    logic [SEQ_W-1:0]      seq_idx_q, seq_idx_d;
    logic                  flush_q, flush_d;
    logic [SH_W-1:0]       pad_shift;

    // ---------------- FIFO ----------------
    logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FIFO_CW-1:0]    fifo_cnt_q, fifo_cnt_d;
    logic                  fifo_empty, fifo_full;
    logic                  push_req, fifo_push, fifo_pop;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  overflow_q, overflow_d;

    // ---------------- burst FSM ----------------
    state_t                state_q, state_d;
    logic [ADDR_SIZE-1:0]  addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic                  req_q, req_d;
    logic                  done_q, done_d;
    logic                  flush_ready;
    logic                  wb_done_cond;

    assign pad_shift = SH_W'(DATA_WIDTH) - {1'b0, beat_cnt_q};

    always_comb begin
        shreg_d    = shreg_q;
        hold_d     = hold_q;
        beat_cnt_d = beat_cnt_q;
        seq_busy_d = seq_busy_q;
        seq_idx_d  = seq_idx_q;
        if (seq_busy_q) begin
            if (seq_idx_q == SEQ_W'(TIME_STEPS - 1)) begin
                seq_busy_d = 1'b0;
                seq_idx_d  = '0;
            end else begin
                seq_idx_d = seq_idx_q + 1'b1;
            end
        end
        if (i_spike_valid) begin
            for (int t = 0; t < TIME_STEPS; t++) begin
                shreg_d[t] = {i_spike[t], shreg_q[t][DATA_WIDTH-1:1]};
            end
            if (beat_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                beat_cnt_d = '0;
                hold_d     = shreg_d;
                seq_busy_d = 1'b1;
                seq_idx_d  = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end else if (flush_q && (beat_cnt_q != '0) && !seq_busy_q) begin
            // Partial tail: align beat 0 to bit 0, upper bits become zero padding.
            for (int t = 0; t < TIME_STEPS; t++) begin
                hold_d[t]  = shreg_q[t] >> pad_shift;
                shreg_d[t] = '0;
            end
            beat_cnt_d = '0;
            seq_busy_d = 1'b1;
            seq_idx_d  = '0;
        end
    end

    assign push_req  = seq_busy_q;
    assign push_data = hold_q[seq_idx_q];

    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == FIFO_CW'(FIFO_DEPTH));
    assign fifo_pop   = wr_burst_data_req && !fifo_empty &&
                        ((state_q == ST_REQ) || (state_q == ST_DATA));
    assign fifo_push  = push_req && (!fifo_full || fifo_pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        overflow_d = overflow_q;
        if (fifo_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        fifo_cnt_d = fifo_cnt_q + FIFO_CW'(fifo_push) - FIFO_CW'(fifo_pop);
        if (push_req && !fifo_push) begin
            overflow_d = 1'b1;
        end
    end

    // Flush bursts wait until the packer has drained so the tail goes out as one burst.
    assign flush_ready  = flush_q && !seq_busy_q && (beat_cnt_q == '0);
    assign wb_done_cond = flush_ready && fifo_empty && !i_spike_valid && (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        flush_d = flush_q;
        done_d  = wb_done_cond;
        case (state_q)
            ST_IDLE: begin
                if ((fifo_cnt_q >= FIFO_CW'(BURST_LEN)) || (flush_ready && !fifo_empty)) begin
                    state_d = ST_REQ;
                    len_d   = (fifo_cnt_q >= FIFO_CW'(BURST_LEN)) ? LEN_WIDTH'(BURST_LEN)
                                                                  : LEN_WIDTH'(fifo_cnt_q);
                end
            end
            ST_REQ: begin
                if (fifo_pop) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (wr_burst_finish) begin
                    state_d = ST_ADV;
                end
            end
            ST_ADV: begin
                addr_d  = addr_q + (ADDR_SIZE'(len_q) * ADDR_SIZE'(DATA_WIDTH / 8));
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (wb_done_cond) begin
            flush_d = 1'b0;
            addr_d  = BASE_ADDR;
        end
        if (i_enc_done) begin
            flush_d = 1'b1;
        end
        req_d = (state_d == ST_REQ);
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            for (int t = 0; t < TIME_STEPS; t++) begin
                shreg_q[t] <= '0;
                hold_q[t]  <= '0;
            end
            beat_cnt_q <= '0;
            seq_busy_q <= 1'b0;
            seq_idx_q  <= '0;
            flush_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            addr_q     <= BASE_ADDR;
            len_q      <= '0;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            hold_q     <= hold_d;
            beat_cnt_q <= beat_cnt_d;
            seq_busy_q <= seq_busy_d;
            seq_idx_q  <= seq_idx_d;
            flush_q    <= flush_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            req_q      <= req_d;
            done_q     <= done_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge s_clk) begin
        if (fifo_push) begin
            fifo_mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign wr_burst_data = fifo_empty ? '0 : fifo_mem_q[rd_ptr_q];
    assign wr_burst_addr = addr_q;
    assign wr_burst_len  = len_q;
    assign wr_burst_req  = req_q;
    assign o_wb_done     = done_q;
    assign o_overflow    = overflow_q;
    assign o_dbg_state   = state_q;

`ifdef SPIKE_WB_COUNT_EN
    logic [15:0] spike_cnt_q [TIME_STEPS];
    logic [15:0] spike_cnt_d [TIME_STEPS];

    always_comb begin
        spike_cnt_d = spike_cnt_q;
        for (int t = 0; t < TIME_STEPS; t++) begin
            if (done_q) begin
                spike_cnt_d[t] = '0;
            end else if (i_spike_valid && i_spike[t] && (spike_cnt_q[t] != 16'hFFFF)) begin
                spike_cnt_d[t] = spike_cnt_q[t] + 1'b1;
            end
        end
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            for (int t = 0; t < TIME_STEPS; t++) begin
                spike_cnt_q[t] <= '0;
            end
        end else begin
            spike_cnt_q <= spike_cnt_d;
        end
    end

    always_comb begin
        o_spike_cnt = '0;
        for (int t = 0; t < TIME_STEPS; t++) begin
            o_spike_cnt[t*16 +: 16] = spike_cnt_q[t];
        end
    end
`endif

endmodule

// File: tb/tb_spike_writeback.sv
// Directed testbench for spike_writeback: acts as encoder and zero-latency arbiter,
// checking burst address/length/data against a queue of hand-computed words.
module tb_spike_writeback;

    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ALT   = 64'h5555_5555_5555_5555;

    logic        s_clk = 1'b0;
    logic        s_rst = 1'b1;
    logic [3:0]  i_spike = '0;
    logic        i_spike_valid = 1'b0;
    logic        i_enc_done = 1'b0;
    logic [63:0] wr_burst_data;
    logic [31:0] wr_burst_addr;
    logic [9:0]  wr_burst_len;
    logic        wr_burst_req;
    logic        wr_burst_data_req = 1'b0;
    logic        wr_burst_finish = 1'b0;
    logic        o_wb_done;
    logic        o_overflow;
    logic [1:0]  o_dbg_state;
`ifdef SPIKE_WB_COUNT_EN
    logic [63:0] o_spike_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    spike_writeback dut (
        .s_clk             (s_clk),
        .s_rst             (s_rst),
        .i_spike           (i_spike),
        .i_spike_valid     (i_spike_valid),
        .i_enc_done        (i_enc_done),
        .wr_burst_data     (wr_burst_data),
        .wr_burst_addr     (wr_burst_addr),
        .wr_burst_len      (wr_burst_len),
        .wr_burst_req      (wr_burst_req),
        .wr_burst_data_req (wr_burst_data_req),
        .wr_burst_finish   (wr_burst_finish),
        .o_wb_done         (o_wb_done),
        .o_overflow        (o_overflow),
        .o_dbg_state       (o_dbg_state)
`ifdef SPIKE_WB_COUNT_EN
        ,
        .o_spike_cnt       (o_spike_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 s_clk = ~s_clk;

    // ---------------- driver tasks (all called at a negedge) ----------------
    task automatic send_beats(input int n, input logic [3:0] a, input logic [3:0] b,
                              input bit done_on_last);
        for (int i = 0; i < n; i++) begin
            i_spike_valid = 1'b1;
            i_spike       = (i % 2 == 0) ? a : b;
            i_enc_done    = done_on_last && (i == n - 1);
            @(negedge s_clk);
        end
        i_spike_valid = 1'b0;
        i_spike       = '0;
        i_enc_done    = 1'b0;
    endtask

    task automatic pulse_done();
        i_enc_done = 1'b1;
        @(negedge s_clk);
        i_enc_done = 1'b0;
    endtask

    task automatic push_pattern(input int packs, input logic [63:0] w0, input logic [63:0] w1,
                                input logic [63:0] w2, input logic [63:0] w3);
        for (int p = 0; p < packs; p++) begin
            exp_q.push_back(w0);
            exp_q.push_back(w1);
            exp_q.push_back(w2);
            exp_q.push_back(w3);
        end
    endtask

    // Zero-latency arbiter: waits for req, then consumes exp_len words back to back.
    task automatic serve_burst(input string name, input logic [31:0] exp_addr,
                               input logic [9:0] exp_len);
        int waited = 0;
        logic [63:0] exp_w;
        while (wr_burst_req !== 1'b1 && waited < 500) begin
            @(negedge s_clk);
            waited++;
        end
        checks++;
        if (wr_burst_req !== 1'b1) begin
            errors++;
            $display("FAIL %s_req_timeout got req=%b want 1", name, wr_burst_req);
            return;
        end
        checks++;
        if (wr_burst_addr !== exp_addr) begin
            errors++;
            $display("FAIL %s_addr got %h want %h", name, wr_burst_addr, exp_addr);
        end
        checks++;
        if (wr_burst_len !== exp_len) begin
            errors++;
            $display("FAIL %s_len got %0d want %0d", name, wr_burst_len, exp_len);
        end
        for (int i = 0; i < int'(exp_len); i++) begin
            if (i == 1) begin
                checks++;
                if (wr_burst_req !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_req_drop got %b want 0", name, wr_burst_req);
                end
            end
            exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 64'h0;
            checks++;
            if (wr_burst_data !== exp_w) begin
                errors++;
                $display("FAIL %s_word%0d got %h want %h", name, i, wr_burst_data, exp_w);
            end
            wr_burst_data_req = 1'b1;
            @(negedge s_clk);
        end
        wr_burst_data_req = 1'b0;
        checks++;
        if (wr_burst_addr !== exp_addr) begin
            errors++;
            $display("FAIL %s_addr_stable got %h want %h", name, wr_burst_addr, exp_addr);
        end
        wr_burst_finish = 1'b1;
        @(negedge s_clk);
        wr_burst_finish = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int waited = 0;
        while (o_wb_done !== 1'b1 && waited < 100) begin
            @(negedge s_clk);
            waited++;
        end
        checks++;
        if (o_wb_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_timeout got %b want 1", name, o_wb_done);
        end
        @(negedge s_clk);
        checks++;
        if (o_wb_done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse got %b want 0", name, o_wb_done);
        end
        checks++;
        if (wr_burst_addr !== BASE) begin
            errors++;
            $display("FAIL %s_addr_rewind got %h want %h", name, wr_burst_addr, BASE);
        end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        repeat (2) @(negedge s_clk);
        checks++;
        if ({wr_burst_req, o_wb_done, o_overflow} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b want 000", {wr_burst_req, o_wb_done, o_overflow});
        end
        checks++;
        if (wr_burst_addr !== BASE) begin
            errors++;
            $display("FAIL reset_addr got %h want %h", wr_burst_addr, BASE);
        end
        checks++;
        if (wr_burst_len !== 10'd0 || wr_burst_data !== 64'h0 || o_dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_len_data_state got len=%0d data=%h st=%0d want 0 0 0",
                     wr_burst_len, wr_burst_data, o_dbg_state);
        end
        s_rst = 1'b0;
        @(negedge s_clk);
    endtask

    task automatic test_single_step();
        send_beats(128, 4'b0001, 4'b0001, 1'b0);
        repeat (10) @(negedge s_clk);
        checks++;
        if (wr_burst_req !== 1'b0) begin
            errors++;
            $display("FAIL single_no_early_burst got req=%b want 0", wr_burst_req);
        end
        push_pattern(2, ONES, 64'h0, 64'h0, 64'h0);
        pulse_done();
        serve_burst("single", BASE, 10'd8);
        wait_done("single");
    endtask

    task automatic test_alternating();
        send_beats(256, 4'b1111, 4'b0000, 1'b0);
        push_pattern(4, ALT, ALT, ALT, ALT);
        serve_burst("alt", BASE, 10'd16);
        send_beats(64, 4'b0000, 4'b0000, 1'b0);
        push_pattern(1, 64'h0, 64'h0, 64'h0, 64'h0);
        pulse_done();
        serve_burst("alt_flush", BASE + 32'd128, 10'd4);
        wait_done("alt");
    endtask

    task automatic test_padded();
        send_beats(10, 4'b0010, 4'b0010, 1'b0);
        pulse_done();
        push_pattern(1, 64'h0, 64'h0000_0000_0000_03FF, 64'h0, 64'h0);
        serve_burst("pad", BASE, 10'd4);
        wait_done("pad");
    endtask

    task automatic test_done_with_last_beat();
        send_beats(64, 4'b0100, 4'b0100, 1'b1);
        push_pattern(1, 64'h0, 64'h0, ONES, 64'h0);
        serve_burst("done_last", BASE, 10'd4);
        wait_done("done_last");
    endtask

    task automatic test_overflow();
        checks++;
        if (o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_before got %b want 0", o_overflow);
        end
        send_beats(1600, 4'b0001, 4'b0001, 1'b0);
        repeat (400) @(negedge s_clk);
        checks++;
        if (o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got %b want 1", o_overflow);
        end
        checks++;
        if (wr_burst_req !== 1'b1 || wr_burst_data !== ONES) begin
            errors++;
            $display("FAIL ovf_stall_head got req=%b head=%h want 1 %h",
                     wr_burst_req, wr_burst_data, ONES);
        end
        push_pattern(4, ONES, 64'h0, 64'h0, 64'h0);
        serve_burst("ovf", BASE, 10'd16);
        s_rst = 1'b1;
        @(negedge s_clk);
        s_rst = 1'b0;
        checks++;
        if (o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_reset got %b want 0", o_overflow);
        end
    endtask

    task automatic test_reset_mid_burst();
        int waited = 0;
        logic [63:0] exp_w;
        send_beats(256, 4'b1111, 4'b0000, 1'b0);
        push_pattern(4, ALT, ALT, ALT, ALT);
        while (wr_burst_req !== 1'b1 && waited < 100) begin
            @(negedge s_clk);
            waited++;
        end
        for (int i = 0; i < 5; i++) begin
            exp_w = exp_q.pop_front();
            checks++;
            if (wr_burst_data !== exp_w) begin
                errors++;
                $display("FAIL rst_mid_word%0d got %h want %h", i, wr_burst_data, exp_w);
            end
            wr_burst_data_req = 1'b1;
            @(negedge s_clk);
        end
        wr_burst_data_req = 1'b0;
        checks++;
        if (o_dbg_state !== 2'd2) begin
            errors++;
            $display("FAIL rst_mid_in_data got state=%0d want 2", o_dbg_state);
        end
        s_rst = 1'b1;
        #1;
        checks++;
        if ({wr_burst_req, o_wb_done, o_overflow} !== 3'b000 || wr_burst_addr !== BASE ||
            wr_burst_len !== 10'd0 || wr_burst_data !== 64'h0 || o_dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs got req=%b addr=%h len=%0d data=%h st=%0d want 0 %h 0 0 0",
                     wr_burst_req, wr_burst_addr, wr_burst_len, wr_burst_data, o_dbg_state, BASE);
        end
        exp_q.delete();
        @(negedge s_clk);
        s_rst = 1'b0;
        @(negedge s_clk);
        send_beats(64, 4'b0001, 4'b0001, 1'b0);
        push_pattern(1, ONES, 64'h0, 64'h0, 64'h0);
        pulse_done();
        serve_burst("rst_after", BASE, 10'd4);
        wait_done("rst_after");
    endtask

`ifdef SPIKE_WB_COUNT_EN
    task automatic test_spike_cnt();
        send_beats(100, 4'b1001, 4'b1001, 1'b0);
        checks++;
        if (o_spike_cnt[15:0] !== 16'd100 || o_spike_cnt[63:48] !== 16'd100) begin
            errors++;
            $display("FAIL cnt_ones got t0=%0d t3=%0d want 100 100",
                     o_spike_cnt[15:0], o_spike_cnt[63:48]);
        end
        checks++;
        if (o_spike_cnt[31:16] !== 16'd0 || o_spike_cnt[47:32] !== 16'd0) begin
            errors++;
            $display("FAIL cnt_zeros got t1=%0d t2=%0d want 0 0",
                     o_spike_cnt[31:16], o_spike_cnt[47:32]);
        end
    endtask
`endif

    // ---------------- sequence and final report ----------------
    initial begin
        @(negedge s_clk);
        test_reset();
        test_single_step();
        test_alternating();
        test_padded();
        test_done_with_last_beat();
        test_overflow();
        test_reset_mid_burst();
`ifdef SPIKE_WB_COUNT_EN
        test_spike_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
